// File: rtl/fifo_sync_v2.sv
// Synchronous FIFO with extended pointers, show-ahead read, occupancy count and programmable thresholds.
// Optional sticky overflow/underflow flags are built only when FIFO_ERROR_FLAGS_EN is defined.
module fifo_sync_v2 #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  flush_i,
    input  logic [DATA_WIDTH-1:0] write_data_i,
    input  logic                  write_enable_i,
    output logic                  write_ready_o,
    input  logic                  read_enable_i,
    output logic [DATA_WIDTH-1:0] read_data_o,
    output logic                  read_valid_o,
    input  logic [ADDR_WIDTH:0]   almost_empty_level_i,
    input  logic [ADDR_WIDTH:0]   almost_full_level_i,
    output logic [ADDR_WIDTH:0]   count_o,
    output logic                  fifo_empty_o,
    output logic                  fifo_almost_empty_o,
    output logic                  fifo_almost_full_o,
    output logic                  fifo_full_o,
    output logic                  overflow_o,
    output logic                  underflow_o
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] PTR_ONE = 1;

    logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];

    // Declaration initialisers give power-up values identical to the reset values.
    logic [ADDR_WIDTH:0] r_wr_ptr       = '0;
    logic [ADDR_WIDTH:0] r_rd_ptr       = '0;
    logic [ADDR_WIDTH:0] r_count        = '0;
    logic                r_write_ready  = 1'b1;
    logic                r_read_valid   = 1'b0;
    logic                r_empty        = 1'b1;
    logic                r_full         = 1'b0;
    logic                r_almost_empty = 1'b1;
    logic                r_almost_full  = 1'b0;

    logic                w_push;
    logic                w_pop;
    logic [ADDR_WIDTH:0] w_wr_ptr_next;
    logic [ADDR_WIDTH:0] w_rd_ptr_next;
    logic [ADDR_WIDTH:0] w_count_next;
    logic                w_empty_next;
    logic                w_full_next;

    // Acceptance uses the registered ready/valid, so a full FIFO never takes a push
    // even when a pop happens in the same cycle.
    assign w_push = write_enable_i && r_write_ready && !flush_i;
    assign w_pop  = read_enable_i  && r_read_valid  && !flush_i;

    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        w_wr_ptr_next = r_wr_ptr;
        w_rd_ptr_next = r_rd_ptr;
        if (flush_i) begin
            w_wr_ptr_next = '0;
            w_rd_ptr_next = '0;
        end else begin
            if (w_push) w_wr_ptr_next = r_wr_ptr + PTR_ONE;
            if (w_pop)  w_rd_ptr_next = r_rd_ptr + PTR_ONE;
        end
        w_count_next = w_wr_ptr_next - w_rd_ptr_next;
        w_empty_next = (w_wr_ptr_next == w_rd_ptr_next);
        w_full_next  = (w_wr_ptr_next[ADDR_WIDTH] != w_rd_ptr_next[ADDR_WIDTH]) &&
                       (w_wr_ptr_next[ADDR_WIDTH-1:0] == w_rd_ptr_next[ADDR_WIDTH-1:0]);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_write_ready  <= 1'b1;
            r_read_valid   <= 1'b0;
            r_empty        <= 1'b1;
            r_full         <= 1'b0;
            r_almost_empty <= 1'b1;
            r_almost_full  <= 1'b0;
        end else begin
            r_wr_ptr       <= w_wr_ptr_next;
            r_rd_ptr       <= w_rd_ptr_next;
            r_count        <= w_count_next;
            r_write_ready  <= !w_full_next;
            r_read_valid   <= !w_empty_next;
            r_empty        <= w_empty_next;
            r_full         <= w_full_next;
            r_almost_empty <= (w_count_next <= almost_empty_level_i);
            r_almost_full  <= (w_count_next >= almost_full_level_i);
        end
    end

    // NOTE: storage has no reset; stale contents are unreachable once the pointers are cleared.
    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= write_data_i;
    end

    assign read_data_o         = r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
    assign write_ready_o       = r_write_ready;
    assign read_valid_o        = r_read_valid;
    assign count_o             = r_count;
    assign fifo_empty_o        = r_empty;
    assign fifo_full_o         = r_full;
    assign fifo_almost_empty_o = r_almost_empty;
    assign fifo_almost_full_o  = r_almost_full;

`ifdef FIFO_ERROR_FLAGS_EN
    logic r_overflow  = 1'b0;
    logic r_underflow = 1'b0;

    // Only reset clears the error flags; flush leaves them untouched.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (write_enable_i && !r_write_ready && !flush_i) r_overflow  <= 1'b1;
            if (read_enable_i  && !r_read_valid  && !flush_i) r_underflow <= 1'b1;
        end
    end

    assign overflow_o  = r_overflow;
    assign underflow_o = r_underflow;
`else
    assign overflow_o  = 1'b0;
    assign underflow_o = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_sync_v2.sv
// Self-checking bench for fifo_sync_v2: directed scenarios then random traffic,
// compared every cycle against a queue-based model of the FIFO.
module tb_fifo_sync_v2;

    localparam int DW  = 16;
    localparam int AW  = 3;
    localparam int CAP = 1 << AW;

    logic          clk_i = 1'b0;
    logic          reset_i = 1'b1;
    logic          flush_i = 1'b0;
    logic [DW-1:0] write_data_i = '0;
    logic          write_enable_i = 1'b0;
    logic          write_ready_o;
    logic          read_enable_i = 1'b0;
    logic [DW-1:0] read_data_o;
    logic          read_valid_o;
    logic [AW:0]   almost_empty_level_i = 4'd2;
    logic [AW:0]   almost_full_level_i = 4'd6;
    logic [AW:0]   count_o;
    logic          fifo_empty_o;
    logic          fifo_almost_empty_o;
    logic          fifo_almost_full_o;
    logic          fifo_full_o;
    logic          overflow_o;
    logic          underflow_o;

    fifo_sync_v2 #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .flush_i(flush_i),
        .write_data_i(write_data_i), .write_enable_i(write_enable_i),
        .write_ready_o(write_ready_o), .read_enable_i(read_enable_i),
        .read_data_o(read_data_o), .read_valid_o(read_valid_o),
        .almost_empty_level_i(almost_empty_level_i),
        .almost_full_level_i(almost_full_level_i), .count_o(count_o),
        .fifo_empty_o(fifo_empty_o), .fifo_almost_empty_o(fifo_almost_empty_o),
        .fifo_almost_full_o(fifo_almost_full_o), .fifo_full_o(fifo_full_o),
        .overflow_o(overflow_o), .underflow_o(underflow_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Reference model: contents as a queue plus sticky flags and the post-reset override.
    logic [DW-1:0] q[$];
    bit            m_ovf = 0;
    bit            m_unf = 0;
    bit            m_after_reset = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int  n;
        bit  exp_ae;
        bit  exp_af;
        bit  exp_ovf;
        bit  exp_unf;
        n = q.size();
        exp_ae = m_after_reset ? 1'b1 : (n <= int'(almost_empty_level_i));
        exp_af = m_after_reset ? 1'b0 : (n >= int'(almost_full_level_i));
`ifdef FIFO_ERROR_FLAGS_EN
        exp_ovf = m_ovf;
        exp_unf = m_unf;
`else
        exp_ovf = 1'b0;
        exp_unf = 1'b0;
`endif
        check("count", 32'(count_o), 32'(n));
        check("empty", 32'(fifo_empty_o), 32'(n == 0));
        check("full", 32'(fifo_full_o), 32'(n == CAP));
        check("write_ready", 32'(write_ready_o), 32'(n != CAP));
        check("read_valid", 32'(read_valid_o), 32'(n != 0));
        check("almost_empty", 32'(fifo_almost_empty_o), 32'(exp_ae));
        check("almost_full", 32'(fifo_almost_full_o), 32'(exp_af));
        check("overflow", 32'(overflow_o), 32'(exp_ovf));
        check("underflow", 32'(underflow_o), 32'(exp_unf));
        if (n != 0) check("read_data", 32'(read_data_o), 32'(q[0]));
    endtask

    // One clock cycle: drive inputs, update the model from the pre-edge state, check after the edge.
    task automatic step(input bit we, input logic [DW-1:0] d, input bit re,
                        input bit fl, input bit rs);
        bit can_push;
        bit can_pop;
        write_enable_i = we;
        write_data_i   = d;
        read_enable_i  = re;
        flush_i        = fl;
        reset_i        = rs;
        can_push = q.size() < CAP;
        can_pop  = q.size() > 0;
        @(posedge clk_i);
        if (rs) begin
            q.delete();
            m_ovf = 0;
            m_unf = 0;
            m_after_reset = 1;
        end else begin
            m_after_reset = 0;
            if (fl) begin
                q.delete();
            end else begin
                if (we && !can_push) m_ovf = 1;
                if (re && !can_pop)  m_unf = 1;
                if (re && can_pop)   void'(q.pop_front());
                if (we && can_push)  q.push_back(d);
            end
        end
        #1;
        check_all();
    endtask

    task automatic idle();
        step(0, '0, 0, 0, 0);
    endtask

    initial begin
        logic [DW-1:0] d;
        // Reset
        step(0, '0, 0, 0, 1);

        // Fill with 0x1111..0x8888, then a dropped 9th push
        for (int i = 1; i <= CAP; i++) step(1, DW'(i * 16'h1111), 0, 0, 0);
        step(1, 16'hDEAD, 0, 0, 0);

        // Drain all eight, then one pop too many
        for (int i = 0; i < CAP; i++) step(0, '0, 1, 0, 0);
        step(0, '0, 1, 0, 0);

        // Single push into empty: visible the next cycle
        step(1, 16'hA5A5, 0, 0, 0);
        check("a5a5_data", 32'(read_data_o), 32'h0000_A5A5);
        check("a5a5_valid", 32'(read_valid_o), 32'd1);
        step(0, '0, 1, 0, 0);

        // Steady state at count 4 across pointer wrap
        for (int i = 0; i < 4; i++) step(1, DW'(16'h4000 + i), 0, 0, 0);
        for (int i = 0; i < 20; i++) step(1, DW'(16'h5000 + i), 1, 0, 0);

        // Flush at count 5 together with a push of 0xBEEF
        step(1, 16'h6000, 0, 0, 0);
        step(1, 16'hBEEF, 0, 1, 0);
        step(1, 16'h1234, 0, 0, 0);
        check("post_flush_head", 32'(read_data_o), 32'h0000_1234);
        step(0, '0, 1, 0, 0);

        // Reach count 3 with overflow set, then reset mid-operation
        for (int i = 0; i < CAP; i++) step(1, DW'(16'h7000 + i), 0, 0, 0);
        step(1, 16'hDEAD, 0, 0, 0);
        for (int i = 0; i < CAP - 3; i++) step(0, '0, 1, 0, 0);
        step(1, 16'h9999, 1, 0, 1);

        // Almost-empty level change at count 1
        step(1, 16'hC0DE, 0, 0, 0);
        almost_empty_level_i = 4'd0;
        idle();
        almost_empty_level_i = 4'd2;

        // Out-of-range levels: AF > CAP never asserts, AE >= CAP always asserts
        almost_full_level_i  = 4'd9;
        almost_empty_level_i = 4'd8;
        for (int i = 0; i < CAP; i++) step(1, DW'(16'h3000 + i), 0, 0, 0);
        idle();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                almost_empty_level_i = 4'($urandom_range(0, 15));
                almost_full_level_i  = 4'($urandom_range(0, 15));
            end
            d = DW'($urandom);
            step(bit'($urandom_range(0, 99) < 55), d, bit'($urandom_range(0, 99) < 45),
                 $urandom_range(0, 39) == 0, $urandom_range(0, 149) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_sync_v2.md
Name: fifo_sync_v2

Overview:
Second-generation synchronous FIFO for the SoC's peripheral and bus datapaths (UART, keyboard, video command queues). Improvements over the first-generation FIFO:
- full 2**ADDR_WIDTH capacity using extended pointers
- show-ahead read port
- occupancy count output
- run-time programmable almost-empty/almost-full levels
- flush that takes priority over all traffic
- optional sticky overflow/underflow error flags

Parameters:
DATA_WIDTH, 16, width of each entry in bits.
ADDR_WIDTH, 5, log2 of depth; CAPACITY = 2**ADDR_WIDTH entries (all usable).

Ports:
clk_i  in  1  system clock; all logic on rising edge.
reset_i  in  1  synchronous, active-high reset.
flush_i  in  1  synchronous empty request; priority over read/write.
write_data_i  in  DATA_WIDTH  data to push.
write_enable_i  in  1  push request.
write_ready_o  out  1  registered; 1 when FIFO is not full.
read_enable_i  in  1  pop request.
read_data_o  out  DATA_WIDTH  head entry (show-ahead); undefined when read_valid_o=0.
read_valid_o  out  1  registered; 1 when FIFO is not empty.
almost_empty_level_i  in  ADDR_WIDTH+1  almost-empty threshold.
almost_full_level_i  in  ADDR_WIDTH+1  almost-full threshold.
count_o  out  ADDR_WIDTH+1  registered occupancy, 0..CAPACITY.
fifo_empty_o  out  1  registered; count_o==0.
fifo_almost_empty_o  out  1  registered; count_o <= almost_empty_level_i (as sampled).
fifo_almost_full_o  out  1  registered; count_o >= almost_full_level_i (as sampled).
fifo_full_o  out  1  registered; count_o==CAPACITY.
overflow_o  out  1  sticky error flag (optional feature).
underflow_o  out  1  sticky error flag (optional feature).

Behaviour:
- Pointers: read_ptr and write_ptr, each ADDR_WIDTH+1 bits. Storage is indexed by the low ADDR_WIDTH bits.
  - Full: MSBs differ and low bits equal.
  - Empty: pointers equal.
  - count = write_ptr - read_ptr, modulo 2**(ADDR_WIDTH+1).
- Push: accepted when write_enable_i && write_ready_o && !flush_i. Writes mem[write_ptr] and increments write_ptr.
- Pop: accepted when read_enable_i && read_valid_o && !flush_i. Increments read_ptr.
- read_data_o: combinational mem[read_ptr low bits]. No read latency once read_valid_o=1.
- Write-to-read latency: push in cycle N into an empty FIFO gives read_valid_o=1 and read_data_o = the pushed data in cycle N+1.
- All status outputs are registered. They are computed from next-state pointers and the level inputs sampled in the same cycle, so they are valid the cycle after any change.
- Simultaneous push and pop, both accepted: count unchanged; all flags hold.
  - When full, write_ready_o=0, so only the pop is accepted; count drops to CAPACITY-1.
  - When empty, read_valid_o=0, so only the push is accepted.
- Wrap-around: pointers wrap naturally through 2**(ADDR_WIDTH+1). No special handling.
- Flush (flush_i=1): next cycle both pointers are 0 and count_o=0.
  - Any concurrent push is discarded; any concurrent pop has no effect.
  - Memory contents are not cleared. Sticky error flags are not cleared.
- Reset (reset_i=1), also mid-operation, next cycle:
  - pointers=0, count_o=0
  - fifo_empty_o=1, read_valid_o=0, write_ready_o=1, fifo_full_o=0
  - fifo_almost_empty_o=1, fifo_almost_full_o=0
  - overflow_o=0, underflow_o=0
  - reset has priority over flush and all traffic.
- Power-up (initial) register values equal the reset values. Memory contents after reset are don't-care.
- Level inputs are unsigned. Values greater than CAPACITY are legal:
  - almost-full level > CAPACITY: almost_full never asserts.
  - almost-empty level >= CAPACITY: almost_empty always asserts.

Optional Feature:
Macro FIFO_ERROR_FLAGS_EN.
- Defined:
  - overflow_o sets when write_enable_i=1 && write_ready_o=0 && !flush_i.
  - underflow_o sets when read_enable_i=1 && read_valid_o=0 && !flush_i.
  - Both flags are set on the following cycle and are sticky until reset_i.
- Not defined: overflow_o and underflow_o are tied to 0 and no flag logic is built.

Test Plan:
All scenarios use DATA_WIDTH=16, ADDR_WIDTH=3 (CAPACITY=8), levels AE=2, AF=6.
- Reset, then push 0x1111..0x8888 over 8 cycles -> count_o steps 1..8; fifo_full_o=1 and write_ready_o=0 after the 8th push; almost_full from count 6; a 9th push of 0xDEAD is dropped; overflow_o=1 if FIFO_ERROR_FLAGS_EN.
- From full, pop 8 times -> read_data_o sequence 0x1111..0x8888; fifo_empty_o=1 next cycle; a further pop sets underflow_o=1 if enabled; count_o=0.
- Push 0xA5A5 into empty -> read_valid_o=1 and read_data_o=0xA5A5 exactly one cycle later.
- Hold count=4, then push and pop every cycle for 20 cycles -> count_o stays 4 throughout pointer wrap; data order preserved; flags stable.
- At count=5, assert flush_i together with write_enable_i=1 (0xBEEF) -> next cycle count_o=0, fifo_empty_o=1; 0xBEEF never appears on the read port; sticky flags unchanged.
- At count=3 with overflow_o=1, assert reset_i -> next cycle count_o=0, read_valid_o=0, write_ready_o=1, fifo_almost_empty_o=1, overflow_o=0; change AE from 2 to 0 at count=1 -> fifo_almost_empty_o=0 next cycle.
